// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the master bit/byte engines.
//   i2c_state_e : receive-engine state encoding (IDLE .. DONE)
//   I2C_ACK     : master drives SDA low after the data word
//   I2C_NACK    : master releases SDA after the data word
//   max2        : helper used to size phase counters
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BIT_LOW  = 3'd1,
        BIT_HIGH = 3'd2,
        ACK_LOW  = 3'd3,
        ACK_HIGH = 3'd4,
        DONE     = 3'd5
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b1;
    localparam logic I2C_NACK = 1'b0;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_scl_phase_timer.sv
// SCL phase timer: counts system clocks inside one SCL low or high phase.
//   clock, reset_n : system clock, asynchronous active-low reset
//   run            : a timed phase is in progress (counter cleared otherwise)
//   sel_high       : 1 = time a high phase (HIGH_CYCLES), 0 = low phase (LOW_CYCLES)
//   hold           : slave is stretching SCL; counter parked at 0
//   phase          : clock index within the current phase
//   terminal       : last clock of the current phase
module i2c_scl_phase_timer
    import i2c_pkg::*;
#(
    parameter int unsigned LOW_CYCLES  = 4,
    parameter int unsigned HIGH_CYCLES = 3,
    parameter int unsigned PHASE_W     = $clog2(max2(LOW_CYCLES, HIGH_CYCLES))
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               sel_high,
    input  logic               hold,
    output logic [PHASE_W-1:0] phase,
    output logic               terminal
);

    localparam logic [PHASE_W-1:0] LOW_LAST  = PHASE_W'(LOW_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HIGH_LAST = PHASE_W'(HIGH_CYCLES - 1);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] last;

    always_comb begin
        last     = sel_high ? HIGH_LAST : LOW_LAST;
        terminal = run && !hold && (phase_q == last);
        // Restart at 0 on every phase boundary so the next phase needs no explicit clear.
        if (!run || terminal || hold) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/i2c_master_read_word.sv
// I2C master receive engine: clocks DATA_WIDTH bits in MSB-first on SDA,
// then drives the master ACK/NACK bit. SCL is generated from the system clock.
//   clock, reset_n : system clock, asynchronous active-low reset
//   go             : level request; starts a transfer when high in IDLE and armed
//   ack_en         : latched at start; 1 = ACK (pull SDA low), 0 = NACK
//   sda            : SDA line input
//   scl_in         : SCL readback, used only when I2C_CLOCK_STRETCH_EN is defined
//   scl            : SCL drive (1 = released)
//   sda_oe         : 1 = pull SDA low
//   data           : received word, updated together with finish
//   finish         : one-cycle completion pulse
//   busy           : high from the first SCL low cycle through DONE
// Optional feature: define I2C_CLOCK_STRETCH_EN to honour slave clock stretching.
// Handshake: go is a level; once finish pulses, go must be seen low in IDLE
// before another transfer can start. go/ack_en changes mid-transfer are ignored.
module i2c_master_read_word
    import i2c_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned LOW_CYCLES    = 4,
    parameter int unsigned HIGH_CYCLES   = 3,
    parameter int unsigned SAMPLE_OFFSET = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic                  ack_en,
    input  logic                  sda,
    input  logic                  scl_in,
    output logic                  scl,
    output logic                  sda_oe,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  finish,
    output logic                  busy
);

    localparam int unsigned PHASE_W = $clog2(max2(LOW_CYCLES, HIGH_CYCLES));
    localparam int unsigned CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PHASE_W-1:0] SAMPLE_IDX = PHASE_W'(SAMPLE_OFFSET);

    i2c_state_e            state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  scl_q, scl_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  finish_q, finish_d;
    logic                  busy_q, busy_d;

    logic                  in_high;
    logic                  run;
    logic                  hold;
    logic [PHASE_W-1:0]    phase;
    logic                  terminal;

    assign in_high = (state_q == BIT_HIGH) || (state_q == ACK_HIGH);
    assign run     = (state_q == BIT_LOW) || (state_q == BIT_HIGH) ||
                     (state_q == ACK_LOW) || (state_q == ACK_HIGH);

`ifdef I2C_CLOCK_STRETCH_EN
    logic scl_meta_q;
    logic scl_sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_in;
            scl_sync_q <= scl_meta_q;
        end
    end

    // A slave holding SCL low freezes the high phase at index 0 until release.
    assign hold = in_high && !scl_sync_q;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    i2c_scl_phase_timer #(
        .LOW_CYCLES  (LOW_CYCLES),
        .HIGH_CYCLES (HIGH_CYCLES),
        .PHASE_W     (PHASE_W)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .sel_high (in_high),
        .hold     (hold),
        .phase    (phase),
        .terminal (terminal)
    );

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        ack_d     = ack_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (!go) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d   = BIT_LOW;
                    ack_d     = ack_en;
                    shift_d   = '0;
                    bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
                end
            end
            BIT_LOW: begin
                if (terminal) state_d = BIT_HIGH;
            end
            BIT_HIGH: begin
                if ((phase == SAMPLE_IDX) && !hold) begin
                    shift_d = (shift_q << 1) | DATA_WIDTH'(sda);
                end
                if (terminal) begin
                    if (bit_cnt_q == '0) begin
                        state_d = ACK_LOW;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        state_d   = BIT_LOW;
                    end
                end
            end
            ACK_LOW: begin
                if (terminal) state_d = ACK_HIGH;
            end
            ACK_HIGH: begin
                if (terminal) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) armed_d = 1'b0;

        // Outputs are registered from the next state so they line up with it.
        scl_d    = !((state_d == BIT_LOW) || (state_d == ACK_LOW));
        sda_oe_d = ((state_d == ACK_LOW) || (state_d == ACK_HIGH)) && (ack_q == I2C_ACK);
        finish_d = (state_d == DONE);
        busy_d   = (state_d != IDLE);
        data_d   = (state_d == DONE) ? shift_q : data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            ack_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            data_q    <= '0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            ack_q     <= ack_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            data_q    <= data_d;
            finish_q  <= finish_d;
            busy_q    <= busy_d;
        end
    end

    assign scl    = scl_q;
    assign sda_oe = sda_oe_q;
    assign data   = data_q;
    assign finish = finish_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_master_read_word.sv
// Directed bench for i2c_master_read_word (default parameters: 8 bits, 4 low, 3 high).
// A small slave model shifts the byte out MSB-first on every SCL falling edge.
module tb_i2c_master_read_word;

    localparam int LATENCY = 64;  // 1 + 9 * (4 + 3)

    logic       clock;
    logic       reset_n;
    logic       go;
    logic       ack_en;
    logic       sda;
    logic       scl_in;
    logic       scl;
    logic       sda_oe;
    logic [7:0] data;
    logic       finish;
    logic       busy;

    int checks;
    int failures;

    logic [7:0] slave_byte;
    int         slave_idx;

    i2c_master_read_word dut (
        .clock   (clock),
        .reset_n (reset_n),
        .go      (go),
        .ack_en  (ack_en),
        .sda     (sda),
        .scl_in  (scl_in),
        .scl     (scl),
        .sda_oe  (sda_oe),
        .data    (data),
        .finish  (finish),
        .busy    (busy)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // slave: present next bit while SCL is low, release SDA for the ACK slot
    always @(negedge scl) begin
        if (slave_idx < 8) sda = slave_byte[7 - slave_idx];
        else               sda = 1'b1;
        slave_idx = slave_idx + 1;
    end

    // Runs one transfer for max_cyc clocks; go is dropped once finish is seen,
    // and ack_en is flipped at clock 10 (it must be ignored).
    task automatic do_transfer(input logic [7:0] b, input logic ack, input int max_cyc,
                               output int lat, output int fin_cnt, output int oe_cnt,
                               output int busy_cnt, output logic [7:0] mid_data);
        lat = -1; fin_cnt = 0; oe_cnt = 0; busy_cnt = 0; mid_data = 8'hxx;
        @(negedge clock);
        slave_byte = b;
        slave_idx  = 0;
        ack_en     = ack;
        go         = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(posedge clock);
            #1;
            if (cyc == 10) ack_en = ~ack;
            if (cyc == 30) mid_data = data;
            if (sda_oe) oe_cnt++;
            if (busy) busy_cnt++;
            if (finish) begin
                fin_cnt++;
                if (lat < 0) lat = cyc;
                go = 1'b0;
            end
        end
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (scl !== 1'b1)    begin failures++; $display("FAIL reset_scl got=%b exp=1", scl); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        checks++; if (data !== 8'h00)  begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", finish); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checks++; if (scl !== 1'b1)  begin failures++; $display("FAIL idle_scl got=%b exp=1", scl); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_ack_read();
        int lat, fin_cnt, oe_cnt, busy_cnt;
        logic [7:0] mid;
        do_transfer(8'hA5, 1'b1, 80, lat, fin_cnt, oe_cnt, busy_cnt, mid);
        checks++; if (lat !== LATENCY) begin failures++; $display("FAIL ack_latency got=%0d exp=%0d", lat, LATENCY); end
        checks++; if (data !== 8'hA5)  begin failures++; $display("FAIL ack_data got=%h exp=a5", data); end
        checks++; if (oe_cnt !== 7)    begin failures++; $display("FAIL ack_sda_oe_cycles got=%0d exp=7", oe_cnt); end
        checks++; if (fin_cnt !== 1)   begin failures++; $display("FAIL ack_finish_count got=%0d exp=1", fin_cnt); end
        checks++; if (busy_cnt !== 64) begin failures++; $display("FAIL ack_busy_cycles got=%0d exp=64", busy_cnt); end
        checks++; if (mid !== 8'h00)   begin failures++; $display("FAIL ack_data_held got=%h exp=00", mid); end
    endtask

    task automatic test_nack_read();
        int lat, fin_cnt, oe_cnt, busy_cnt;
        logic [7:0] mid;
        do_transfer(8'h3C, 1'b0, 80, lat, fin_cnt, oe_cnt, busy_cnt, mid);
        checks++; if (lat !== LATENCY) begin failures++; $display("FAIL nack_latency got=%0d exp=%0d", lat, LATENCY); end
        checks++; if (data !== 8'h3C)  begin failures++; $display("FAIL nack_data got=%h exp=3c", data); end
        checks++; if (oe_cnt !== 0)    begin failures++; $display("FAIL nack_sda_oe_cycles got=%0d exp=0", oe_cnt); end
        checks++; if (fin_cnt !== 1)   begin failures++; $display("FAIL nack_finish_count got=%0d exp=1", fin_cnt); end
        checks++; if (mid !== 8'hA5)   begin failures++; $display("FAIL nack_data_held got=%h exp=a5", mid); end
    endtask

    task automatic test_back_to_back();
        int fin_cnt;
        int lat;
        fin_cnt = 0;
        lat     = -1;
        @(negedge clock);
        slave_byte = 8'h5A;
        slave_idx  = 0;
        ack_en     = 1'b0;
        go         = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clock);
            #1;
            if (finish) fin_cnt++;
        end
        checks++; if (fin_cnt !== 1)  begin failures++; $display("FAIL held_finish_count got=%0d exp=1", fin_cnt); end
        checks++; if (data !== 8'h5A) begin failures++; $display("FAIL held_data got=%h exp=5a", data); end
        @(negedge clock);
        go         = 1'b0;
        slave_byte = 8'hC3;
        slave_idx  = 0;
        @(negedge clock);
        go = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clock);
            #1;
            if (finish && lat < 0) lat = cyc;
        end
        go = 1'b0;
        checks++; if (lat !== LATENCY) begin failures++; $display("FAIL rearm_latency got=%0d exp=%0d", lat, LATENCY); end
        checks++; if (data !== 8'hC3)  begin failures++; $display("FAIL rearm_data got=%h exp=c3", data); end
    endtask

    task automatic test_reset_mid();
        int fin_cnt;
        fin_cnt = 0;
        @(negedge clock);
        slave_byte = 8'hFF;
        slave_idx  = 0;
        ack_en     = 1'b1;
        go         = 1'b1;
        repeat (29) @(posedge clock);
        #2;
        reset_n = 1'b0;
        go      = 1'b0;
        #1;
        checks++; if (scl !== 1'b1)    begin failures++; $display("FAIL abort_scl got=%b exp=1", scl); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL abort_sda_oe got=%b exp=0", sda_oe); end
        checks++; if (data !== 8'h00)  begin failures++; $display("FAIL abort_data got=%h exp=00", data); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clock);
            #1;
            if (finish) fin_cnt++;
        end
        checks++; if (fin_cnt !== 0)  begin failures++; $display("FAIL abort_no_finish got=%0d exp=0", fin_cnt); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL abort_data_after got=%h exp=00", data); end
    endtask

`ifdef I2C_CLOCK_STRETCH_EN
    // Slave holds scl_in low from the third SCL low phase until 10 clocks
    // into the third high phase; the 2-flop synchroniser adds 2 more.
    task automatic test_stretch();
        int lat, falls, rises, k;
        logic prev;
        lat = -1; falls = 0; rises = 0; k = -1;
        @(negedge clock);
        slave_byte = 8'h96;
        slave_idx  = 0;
        ack_en     = 1'b1;
        go         = 1'b1;
        prev       = scl;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(posedge clock);
            #1;
            if (prev && !scl) begin
                falls++;
                if (falls == 3) scl_in = 1'b0;
            end
            if (!prev && scl) begin
                rises++;
                if (rises == 3) k = 0;
            end else if (k >= 0) begin
                k++;
                if (k == 10) begin
                    scl_in = 1'b1;
                    k      = -1;
                end
            end
            prev = scl;
            if (finish && lat < 0) begin
                lat = cyc;
                go  = 1'b0;
            end
        end
        go     = 1'b0;
        scl_in = 1'b1;
        checks++; if (lat !== LATENCY + 12) begin failures++; $display("FAIL stretch_latency got=%0d exp=%0d", lat, LATENCY + 12); end
        checks++; if (data !== 8'h96)       begin failures++; $display("FAIL stretch_data got=%h exp=96", data); end
    endtask
`endif

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        go         = 1'b0;
        ack_en     = 1'b0;
        sda        = 1'b1;
        scl_in     = 1'b1;
        slave_byte = 8'h00;
        slave_idx  = 8;
        test_reset();
        test_ack_read();
        test_nack_read();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_CLOCK_STRETCH_EN
        test_stretch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
